// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU drive/return bus of the Salamander-4 execute core.
// The slave modport is the sequencer side; the master modport is the instruction source / ALU side.
interface alu_sequencer_if #(
   parameter int SIZE = 8
);
   localparam int INSTR_W = SIZE + 8;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic               alu_ce;
   logic [3:0]         alu_op_code;
   logic [SIZE-1:0]    alu_left;
   logic [SIZE-1:0]    alu_right;
   logic               alu_carry_in;
   logic [SIZE-1:0]    alu_op_out;
   logic               alu_carry_out;

   modport slave (
      input  instr_valid, instr, alu_op_out, alu_carry_out,
      output instr_ready, alu_ce, alu_op_code, alu_left, alu_right, alu_carry_in
   );

   modport master (
      output instr_valid, instr, alu_op_out, alu_carry_out,
      input  instr_ready, alu_ce, alu_op_code, alu_left, alu_right, alu_carry_in
   );
endinterface

// File: rtl/alu_sequencer.sv
// Execute/write-back sequencer: IDLE -> EXEC -> WB per instruction, 4-entry register file, carry flag.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN feeds carry_flag into alu_carry_in for carry-producing ops.
module alu_sequencer #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rstn,
   alu_sequencer_if.slave  bus,
   output logic            st_valid,
   output logic [SIZE-1:0] st_data,
   output logic            done,
   output logic            err,
   output logic            carry_flag,
   input  logic [1:0]      dbg_sel,
   output logic [SIZE-1:0] dbg_data
);
   localparam int INSTR_W = SIZE + 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LD  = 4'd6;
   localparam logic [3:0] OP_ST  = 4'd7;
   localparam logic [3:0] OP_INC = 4'd8;
   localparam logic [3:0] OP_DEC = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t                  state_q, state_d;
   logic [INSTR_W-1:0]      instr_q, instr_d;
   logic [3:0][SIZE-1:0]    regs_q, regs_d;
   logic                    carry_q, carry_d;
   logic                    ready_q, ready_d;

   logic [3:0]      op;
   logic [1:0]      rd, rs;
   logic [SIZE-1:0] imm;
   logic            is_alu, is_carry_op, is_rsvd;

   assign op  = instr_q[SIZE+7:SIZE+4];
   assign rd  = instr_q[SIZE+3:SIZE+2];
   assign rs  = instr_q[SIZE+1:SIZE];
   assign imm = instr_q[SIZE-1:0];

   assign is_alu      = (op <= OP_NOT) || ((op >= OP_INC) && (op <= OP_SHR));
   assign is_carry_op = (op == OP_ADD) || (op == OP_SUB) || ((op >= OP_INC) && (op <= OP_SHR));
   assign is_rsvd     = (op > OP_SHR);

   assign bus.instr_ready = ready_q;
   assign carry_flag      = carry_q;
   assign dbg_data        = regs_q[dbg_sel];

   always_comb begin
      state_d          = state_q;
      instr_d          = instr_q;
      regs_d           = regs_q;
      carry_d          = carry_q;
      bus.alu_ce       = 1'b0;
      bus.alu_op_code  = 4'd0;
      bus.alu_left     = '0;
      bus.alu_right    = '0;
      bus.alu_carry_in = 1'b0;
      done             = 1'b0;
      err              = 1'b0;
      st_valid         = 1'b0;
      st_data          = '0;
      case (state_q)
         IDLE: begin
            if (bus.instr_valid && ready_q) begin
               instr_d = bus.instr;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = WB;
            if (is_alu) begin
               bus.alu_ce      = 1'b1;
               bus.alu_op_code = op;
               bus.alu_left    = regs_q[rd];
               bus.alu_right   = regs_q[rs];
`ifdef ALU_SEQ_CARRY_CHAIN_EN
               if (is_carry_op) bus.alu_carry_in = carry_q;
`endif
               regs_d[rd] = bus.alu_op_out;
               if (is_carry_op) carry_d = bus.alu_carry_out;
            end else if (op == OP_LD) begin
               regs_d[rd] = imm;
            end
         end
         WB: begin
            state_d = IDLE;
            done    = 1'b1;
            err     = is_rsvd;
            // Store data comes straight from the file; no write happens in WB so it is stable.
            if (op == OP_ST) begin
               st_valid = 1'b1;
               st_data  = regs_q[rs];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready is registered so it stays low through the first edge after reset release.
   assign ready_d = (state_d == IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         instr_q <= '0;
         regs_q  <= '0;
         carry_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         regs_q  <= regs_d;
         carry_q <= carry_d;
         ready_q <= ready_d;
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU stub on the bus.
module tb_alu_sequencer;
   localparam int SIZE = 8;

   logic            clk;
   logic            rstn;
   logic            st_valid;
   logic [SIZE-1:0] st_data;
   logic            done;
   logic            err;
   logic            carry_flag;
   logic [1:0]      dbg_sel;
   logic [SIZE-1:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   alu_sequencer_if #(.SIZE(SIZE)) bus ();

   alu_sequencer #(.SIZE(SIZE)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus),
      .st_valid   (st_valid),
      .st_data    (st_data),
      .done       (done),
      .err        (err),
      .carry_flag (carry_flag),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: 9-bit result, bit 8 is carry (borrow for SUB/DEC).
   logic [8:0] alu_res;
   always_comb begin
      alu_res = 9'd0;
      case (bus.alu_op_code)
         4'd0:  alu_res = {1'b0, bus.alu_left} + {1'b0, bus.alu_right} + {8'd0, bus.alu_carry_in};
         4'd1:  alu_res = {1'b0, bus.alu_left} - {1'b0, bus.alu_right} - {8'd0, bus.alu_carry_in};
         4'd2:  alu_res = {1'b0, bus.alu_left & bus.alu_right};
         4'd3:  alu_res = {1'b0, bus.alu_left | bus.alu_right};
         4'd4:  alu_res = {1'b0, bus.alu_left ^ bus.alu_right};
         4'd5:  alu_res = {1'b0, ~bus.alu_left};
         4'd8:  alu_res = {1'b0, bus.alu_left} + 9'd1;
         4'd9:  alu_res = {1'b0, bus.alu_left} - 9'd1;
         4'd10: alu_res = {bus.alu_left[7], bus.alu_left[6:0], 1'b0};
         4'd11: alu_res = {bus.alu_left[0], 1'b0, bus.alu_left[7:1]};
         default: alu_res = 9'd0;
      endcase
   end
   assign bus.alu_op_out    = alu_res[7:0];
   assign bus.alu_carry_out = alu_res[8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
      dbg_sel = idx;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   // Values captured during the EXEC and WB cycles of the last instruction.
   logic       ex_ce, ex_cin, ex_rdy, ex_done;
   logic [3:0] ex_op;
   logic [7:0] ex_l, ex_r;
   logic       wb_st, wb_ce;
   logic [7:0] wb_std;
   int         done_cnt = 0;

   task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [7:0] imm, input logic exp_ce, input logic exp_err);
      int n = 0;
      while (bus.instr_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("ready_before_issue", bus.instr_ready, 1);
      bus.instr       = {op, rd, rs, imm};
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      ex_ce = bus.alu_ce; ex_cin = bus.alu_carry_in; ex_rdy = bus.instr_ready;
      ex_done = done; ex_op = bus.alu_op_code; ex_l = bus.alu_left; ex_r = bus.alu_right;
      chk("exec_ce", ex_ce, exp_ce);
      chk("exec_ready_low", ex_rdy, 0);
      chk("exec_done_low", ex_done, 0);
      @(posedge clk); #1;
      wb_st = st_valid; wb_std = st_data; wb_ce = bus.alu_ce;
      chk("wb_done", done, 1);
      chk("wb_err", err, exp_err);
      chk("wb_ce_low", wb_ce, 0);
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
      chk("post_done_low", done, 0);
      chk("post_st_low", st_valid, 0);
      chk("post_ready", bus.instr_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [15:0] strm [4];
   int          acc_cyc [4];
   int          k;
   logic        acc;

   initial begin
      rstn            = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      dbg_sel         = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.instr_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_carry", carry_flag, 0);
      chk("rst_ce", bus.alu_ce, 0);
      chk_reg("rst_r0", 2'd0, 8'h00);
      chk_reg("rst_r3", 2'd3, 8'h00);
      rstn = 1'b1;
      #1;
      chk("ready_before_first_edge", bus.instr_ready, 0);
      @(posedge clk); #1;
      chk("ready_after_first_edge", bus.instr_ready, 1);

      // LD R0,#1; LD R1,#1; ADD R0,R1
      run(4'd6, 2'd0, 2'd0, 8'h01, 1'b0, 1'b0);
      run(4'd6, 2'd1, 2'd0, 8'h01, 1'b0, 1'b0);
      run(4'd0, 2'd0, 2'd1, 8'h00, 1'b1, 1'b0);
      chk("add_opcode", ex_op, 4'd0);
      chk("add_left", ex_l, 8'h01);
      chk("add_right", ex_r, 8'h01);
      chk("add_cin0", ex_cin, 0);
      chk_reg("add_r0", 2'd0, 8'h02);
      chk("add_carry", carry_flag, 0);
      chk("three_done", done_cnt, 3);

      // LD R2,#FF; INC R2 -> 0 with carry; AND keeps carry
      run(4'd6, 2'd2, 2'd0, 8'hFF, 1'b0, 1'b0);
      run(4'd8, 2'd2, 2'd2, 8'h00, 1'b1, 1'b0);
      chk("inc_opcode", ex_op, 4'd8);
      chk_reg("inc_r2", 2'd2, 8'h00);
      chk("inc_carry", carry_flag, 1);
      run(4'd2, 2'd2, 2'd2, 8'h00, 1'b1, 1'b0);
      chk("and_carry_kept", carry_flag, 1);

      // Reserved opcode with carry set: nothing changes
      run(4'hC, 2'd0, 2'd1, 8'h77, 1'b0, 1'b1);
      chk_reg("rsvd_r0", 2'd0, 8'h02);
      chk_reg("rsvd_r1", 2'd1, 8'h01);
      chk_reg("rsvd_r2", 2'd2, 8'h00);
      chk_reg("rsvd_r3", 2'd3, 8'h00);
      chk("rsvd_carry", carry_flag, 1);

      // ADD with carry_flag=1
      run(4'd6, 2'd0, 2'd0, 8'h01, 1'b0, 1'b0);
      run(4'd0, 2'd0, 2'd1, 8'h00, 1'b1, 1'b0);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      chk("chain_cin", ex_cin, 1);
      chk_reg("chain_r0", 2'd0, 8'h03);
`else
      chk("chain_cin", ex_cin, 0);
      chk_reg("chain_r0", 2'd0, 8'h02);
`endif
      chk("chain_carry", carry_flag, 0);

      // LD R3,#A5; ST rs=R3
      run(4'd6, 2'd3, 2'd0, 8'hA5, 1'b0, 1'b0);
      run(4'd7, 2'd1, 2'd3, 8'h00, 1'b0, 1'b0);
      chk("st_valid", wb_st, 1);
      chk("st_data", wb_std, 8'hA5);
      chk_reg("st_r1", 2'd1, 8'h01);
      chk_reg("st_r2", 2'd2, 8'h00);
      chk_reg("st_r3", 2'd3, 8'hA5);

      // Back-to-back stream, then reset during the 4th EXEC
      strm[0] = {4'd6, 2'd0, 2'd0, 8'h03};
      strm[1] = {4'd6, 2'd1, 2'd0, 8'h04};
      strm[2] = {4'd0, 2'd0, 2'd1, 8'h00};
      strm[3] = {4'd0, 2'd1, 2'd0, 8'h00};
      k = 0;
      bus.instr       = strm[0];
      bus.instr_valid = 1'b1;
      for (int c = 0; c < 40 && k < 4; c++) begin
         @(negedge clk);
         acc = bus.instr_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cyc[k] = c;
            k++;
            if (k < 4) bus.instr = strm[k];
         end
      end
      chk("stream_accepts", k, 4);
      chk("stream_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("stream_gap12", acc_cyc[2] - acc_cyc[1], 3);
      chk("stream_gap23", acc_cyc[3] - acc_cyc[2], 3);
      chk("stream4_ce", bus.alu_ce, 1);
      chk_reg("stream_r0", 2'd0, 8'h07);
      rstn            = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      chk("abort_ready", bus.instr_ready, 0);
      chk("abort_ce", bus.alu_ce, 0);
      chk("abort_carry", carry_flag, 0);
      chk_reg("abort_r0", 2'd0, 8'h00);
      chk_reg("abort_r1", 2'd1, 8'h00);
      chk_reg("abort_r3", 2'd3, 8'h00);
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
      chk_reg("abort_r1_after_edge", 2'd1, 8'h00);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rerelease_ready_low", bus.instr_ready, 0);
      @(posedge clk); #1;
      chk("rerelease_ready_high", bus.instr_ready, 1);
      chk("rerelease_done_low", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction sequencer that sits directly upstream and downstream of the `ALU`. It accepts packed instructions over a valid/ready handshake and reads operands from a 4-entry register file. It drives the ALU's CE/OP_CODE/operand/carry inputs for one cycle, then writes `op_out`/`carry_out` back into the register file and the carry flag. LD and ST are handled locally without the ALU. This is the execute/write-back core of the Salamander-4 datapath.

## Interface
- `SIZE`, 8, data width; must match the ALU's `SIZE`.
- `INSTR_W`, `SIZE+8`, derived, not overridable. Instruction layout: op `[SIZE+7:SIZE+4]`, rd `[SIZE+3:SIZE+2]`, rs `[SIZE+1:SIZE]`, imm `[SIZE-1:0]`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept.
- `instr`  in  INSTR_W  packed instruction.
- `alu_ce`  out  1  to ALU `CE`.
- `alu_op_code`  out  4  to ALU `OP_CODE`.
- `alu_left`  out  SIZE  to ALU `left_operand`.
- `alu_right`  out  SIZE  to ALU `right_operand`.
- `alu_carry_in`  out  1  to ALU `carry_in`.
- `alu_op_out`  in  SIZE  from ALU `op_out`.
- `alu_carry_out`  in  1  from ALU `carry_out`.
- `st_valid`  out  1  one-cycle pulse; `st_data` is valid.
- `st_data`  out  SIZE  stored register value.
- `done`  out  1  one-cycle pulse per retired instruction.
- `err`  out  1  one-cycle pulse with `done` for a reserved opcode.
- `carry_flag`  out  1  current carry flag.
- `dbg_sel`  in  2  register-file debug read select.
- `dbg_data`  out  SIZE  combinational `R[dbg_sel]`.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LD=6, ST=7, INC=8, DEC=9, SHL=10, SHR=11. Values 12–15 are reserved.
- States: IDLE, EXEC, WB.
  - IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, latch `instr`, go to EXEC.
  - EXEC: execute the latched instruction (rules below), go to WB.
  - WB: `done`=1 (`err`=1 if reserved), go to IDLE.
- ALU ops (0–5, 8–11) in EXEC:
  - Drive `alu_ce`=1, `alu_op_code`=op, `alu_left`=R[rd], `alu_right`=R[rs].
  - At the end of EXEC: R[rd] ← `alu_op_out`.
  - Carry flag ← `alu_carry_out` only for ADD/SUB/INC/DEC/SHL/SHR. AND/OR/XOR/NOT leave it unchanged.
- LD: `alu_ce`=0. At the end of EXEC, R[rd] ← imm.
- ST: `alu_ce`=0. `st_valid`=1 and `st_data`=R[rs] during the WB cycle. No register write.
- Reserved opcodes: no ALU activity, no register or flag change.
- rd==rs is legal. Operands are read combinationally during EXEC; the write lands at the EXEC→WB edge, so there is no hazard.
- Outside EXEC: `alu_ce`, `alu_op_code`, `alu_left`, `alu_right` and `alu_carry_in` are 0.
- `st_data` is 0 whenever `st_valid`=0.
- Width rule: all register writes take the full SIZE bits. No wider arithmetic is done in this block.

## Timing
- Reset values:
  - state IDLE; R0–R3=0; `carry_flag`=0.
  - `instr_ready`=0; it is a registered output and rises on the first `clk` edge after `rstn` deasserts.
  - All other outputs 0.
- Latency:
  - Accept edge E0; EXEC is the cycle after E0.
  - Write-back at E1; `done` during the cycle after E1.
  - `instr_ready` re-asserts after E2.
  - Sustained throughput: one instruction per 3 cycles with `instr_valid` held high.
- Handshake:
  - `instr` is sampled only on a valid&ready edge.
  - `instr_valid` may drop at any time without effect outside IDLE.
- Reset mid-operation: asserting `rstn` in EXEC or WB aborts the instruction. There is no write-back, `done` and `err` are not pulsed, and all state goes to reset values immediately (asynchronous).
- `dbg_data` reflects a write on the cycle after the write edge.

## Configuration
- Macro `ALU_SEQ_CARRY_CHAIN_EN`:
  - Defined: during EXEC of ADD/SUB/INC/DEC/SHL/SHR, `alu_carry_in` = `carry_flag`.
  - Undefined: `alu_carry_in` is constant 0.

## Test plan
- Reset, then LD R0,#1; LD R1,#1; ADD rd=R0 rs=R1 → `dbg_data[R0]`=0x02, `carry_flag`=0, three `done` pulses, `err` never high.
- LD R2,#0xFF; INC rd=R2 → R2=0x00, `carry_flag`=1. Follow with AND rd=R2 rs=R2 → `carry_flag` remains 1.
- With `carry_flag`=1, R0=1, R1=1, then ADD rd=R0 rs=R1:
  - `ALU_SEQ_CARRY_CHAIN_EN` defined: `alu_carry_in`=1 in EXEC and R0=0x03.
  - Undefined: `alu_carry_in`=0 and R0=0x02.
- LD R3,#0xA5; ST rs=R3 → `st_valid` pulses for 1 cycle with `st_data`=0xA5 in the `done` cycle. `alu_ce` never asserts; registers are unchanged.
- Opcode 0xC → `done`=`err`=1 for one cycle. R0–R3 and `carry_flag` are unchanged; `alu_ce` stays 0.
- `instr_valid` held high with a 4-instruction stream → accepts exactly every 3rd cycle. Asserting `rstn`=0 in EXEC of the 4th instruction → no write-back, all registers 0, `instr_ready`=0 until the first edge after release.
